// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one uart_tx serializer among NUM_REQ byte requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, last_owner, last_owner_n, winner, idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [7:0] tx_data_n;
  logic last_flag, last_flag_n, tx_start_n, timeout_err_n, accept, expired;
  // Scan downward so the closest requester after last_owner is written last and wins.
  always_comb begin
    winner = last_owner;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(last_owner) + 1 + k) % NUM_REQ);
      if (req_valid[idx]) winner = idx;
    end
  end
  assign req_ready = (state == SEND && !tx_busy) ? (req_valid & grant) : '0;
  assign accept = |req_ready;
  assign expired = cnt == CNT_W'(LOCK_TIMEOUT - 1);
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    last_owner_n = last_owner;
    cnt_n = cnt;
    last_flag_n = last_flag;
    tx_start_n = 1'b0;
    tx_data_n = tx_data;
    timeout_err_n = 1'b0;
    case (state)
      IDLE: if (|req_valid) begin
        state_n = SEND;
        owner_n = winner;
        grant_n = NUM_REQ'(1) << winner;
        cnt_n = '0;
      end
      SEND: if (accept) begin
        state_n = WAIT_ACK;
        tx_start_n = 1'b1;
        tx_data_n = req_data[{owner, 3'b000} +: 8];
        last_flag_n = req_last[owner];
        cnt_n = '0;
      end else if (expired) begin
        state_n = IDLE;
        grant_n = '0;
        last_owner_n = owner;
        timeout_err_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      // A serializer that never raises busy must not hold the lock forever.
      WAIT_ACK: if (tx_busy) state_n = WAIT_DONE;
      else if (expired) begin
        state_n = IDLE;
        grant_n = '0;
        last_owner_n = owner;
        timeout_err_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      WAIT_DONE: if (!tx_busy) begin
        state_n = last_flag ? IDLE : SEND;
        grant_n = last_flag ? '0 : grant;
        last_owner_n = last_flag ? owner : last_owner;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      cnt <= '0;
      last_flag <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      last_owner <= last_owner_n;
      cnt <= cnt_n;
      last_flag <= last_flag_n;
      tx_start <= tx_start_n;
      tx_data <= tx_data_n;
      timeout_err <= timeout_err_n;
    end
  end
endmodule
